lcd_bringup_sequencer: RTL and testbench

//  Bring-up and runtime controller for the LCD path: PLL -> VGAMod timing generator -> panel.

---
 rtl/lcd_ctrl_pkg.sv | 28 ++
 rtl/sync_edge_det.sv | 41 ++++
 rtl/lcd_bringup_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_lcd_bringup_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared definitions for the LCD bring-up controller:
//   - lcd_state_e   : sequencer state encodings (3-bit, IDLE..RUN)
//   - lcd_pattern_e : test pattern codes driven to the pattern generator
//   - cnt_width()   : width of a counter that must reach a given count
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_BLANK     = 3'd3,
        ST_RUN       = 3'd4
    } lcd_state_e;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_RED   = 2'd2,
        PAT_WHITE = 2'd3
    } lcd_pattern_e;

    // A parameter of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Two-flop synchronizer for an asynchronous single-bit input, plus a
// registered one-cycle pulse on the synchronized falling edge.
// Ports:
//   CLK_SYS    in   destination clock
//   rst        in   asynchronous reset, active-low
//   async_in   in   signal from another clock domain / pin
//   level      out  synchronized level (2 cycles of latency)
//   fall_pulse out  1-cycle pulse, 3 cycles after the input falls
module sync_edge_det (
    input  logic CLK_SYS,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic fall_pulse
);

    logic meta;
    logic sync_q;
    logic sync_d;

    // Two metastability flops, then one more stage so the edge compare only
    // ever looks at settled values. Everything clears to 0, so an input that
    // is already high at reset release produces a rising edge, never a pulse.
    always_ff @(posedge CLK_SYS or negedge rst) begin
        if (!rst) begin
            meta       <= 1'b0;
            sync_q     <= 1'b0;
            sync_d     <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            meta       <= async_in;
            sync_q     <= meta;
            sync_d     <= sync_q;
            fall_pulse <= sync_d & ~sync_q;
        end
    end

    assign level = sync_q;

endmodule

// File: rtl/lcd_bringup_sequencer.sv
// lcd_bringup_sequencer
// Bring-up and runtime controller for the PLL -> VGAMod -> panel path.
// Holds VGAMod in reset until PLL lock has been stable for LOCK_FILTER cycles,
// waits SETTLE_CYCLES, discards BLANK_FRAMES frames, then enables DE and the
// backlight and steps pattern_sel every PATTERN_FRAMES frames. Any loss of
// lock after the filter drops straight back to LOCK_WAIT.
//
// Build option: define LCD_BL_PWM_EN to drive bl_en from a free-running
// PWM_BITS counter compared against bl_duty; otherwise bl_en is a plain level
// in RUN and bl_duty is ignored.
//
// Ports:
//   CLK_SYS      in   system clock (90 MHz)
//   rst          in   asynchronous reset, active-low
//   pll_lock     in   PLL lock, asynchronous
//   lcd_vsync    in   VSYNC from the timing generator, active-low pulse
//   pattern_hold in   1 = freeze pattern_sel
//   bl_duty      in   backlight duty (PWM build only)
//   vga_rst_n    out  VGAMod nRST
//   lcd_den_en   out  gate for LCD_DEN
//   bl_en        out  backlight enable / PWM
//   pattern_sel  out  test pattern index
//   ready        out  high in RUN
//   state_o      out  current state (debug)
module lcd_bringup_sequencer
    import lcd_ctrl_pkg::*;
#(
    parameter int LOCK_FILTER    = 16,
    parameter int SETTLE_CYCLES  = 900000,
    parameter int BLANK_FRAMES   = 2,
    parameter int PATTERN_FRAMES = 120,
    parameter int PWM_BITS       = 8
) (
    input  logic                CLK_SYS,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                lcd_vsync,
    input  logic                pattern_hold,
    input  logic [PWM_BITS-1:0] bl_duty,
    output logic                vga_rst_n,
    output logic                lcd_den_en,
    output logic                bl_en,
    output logic [1:0]          pattern_sel,
    output logic                ready,
    output logic [2:0]          state_o
);

    localparam int LW = cnt_width(LOCK_FILTER);
    localparam int SW = cnt_width(SETTLE_CYCLES);
    localparam int BW = cnt_width(BLANK_FRAMES);
    localparam int FW = cnt_width(PATTERN_FRAMES);

    // Terminal values; a zero count still spends one cycle in SETTLE.
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_FILTER - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BLANK_LAST  = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(PATTERN_FRAMES - 1);

    lcd_state_e    state;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] settle_cnt;
    logic [BW-1:0] blank_cnt;
    logic [FW-1:0] frame_cnt;

    logic lock_sync;
    logic lock_fall_unused;
    logic vsync_level_unused;
    logic vsync_pulse;
    logic pwm_on;

    sync_edge_det u_lock_sync (
        .CLK_SYS    (CLK_SYS),
        .rst        (rst),
        .async_in   (pll_lock),
        .level      (lock_sync),
        .fall_pulse (lock_fall_unused)
    );

    sync_edge_det u_vsync_sync (
        .CLK_SYS    (CLK_SYS),
        .rst        (rst),
        .async_in   (lcd_vsync),
        .level      (vsync_level_unused),
        .fall_pulse (vsync_pulse)
    );

`ifdef LCD_BL_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    // Free-running PWM timebase; it never stops, so the duty ratio holds over
    // any window of 2**PWM_BITS cycles regardless of when RUN was entered.
    always_ff @(posedge CLK_SYS or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt < bl_duty);
`else
    logic bl_duty_unused;
    assign bl_duty_unused = ^bl_duty;
    assign pwm_on         = 1'b1;
`endif

    // Sequencer. Lock loss is checked before anything else so a frame pulse
    // arriving on the same cycle can never advance a counter or the pattern.
    // Outputs are registered alongside the state so they change on the same
    // edge as state_o.
    always_ff @(posedge CLK_SYS or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            lock_cnt    <= '0;
            settle_cnt  <= '0;
            blank_cnt   <= '0;
            frame_cnt   <= '0;
            vga_rst_n   <= 1'b0;
            lcd_den_en  <= 1'b0;
            bl_en       <= 1'b0;
            ready       <= 1'b0;
            pattern_sel <= PAT_BARS;
        end else if (((state == ST_SETTLE) || (state == ST_BLANK) || (state == ST_RUN)) && !lock_sync) begin
            state      <= ST_LOCK_WAIT;
            lock_cnt   <= '0;
            settle_cnt <= '0;
            blank_cnt  <= '0;
            frame_cnt  <= '0;
            vga_rst_n  <= 1'b0;
            lcd_den_en <= 1'b0;
            bl_en      <= 1'b0;
            ready      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_LOCK_WAIT;
                end

                ST_LOCK_WAIT: begin
                    if (!lock_sync) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state      <= ST_SETTLE;
                        lock_cnt   <= '0;
                        settle_cnt <= '0;
                        vga_rst_n  <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_BLANK;
                        settle_cnt <= '0;
                        blank_cnt  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_BLANK: begin
                    if ((BLANK_FRAMES == 0) || (vsync_pulse && (blank_cnt == BLANK_LAST))) begin
                        state      <= ST_RUN;
                        blank_cnt  <= '0;
                        frame_cnt  <= '0;
                        lcd_den_en <= 1'b1;
                        bl_en      <= pwm_on;
                        ready      <= 1'b1;
                    end else if (vsync_pulse) begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    bl_en <= pwm_on;
                    if (pattern_hold) begin
                        frame_cnt <= '0;
                    end else if (vsync_pulse) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt   <= '0;
                            pattern_sel <= pattern_sel + 2'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_lcd_bringup_sequencer.sv
// tb_lcd_bringup_sequencer
// Self-checking bench for lcd_bringup_sequencer with small parameters
// (LOCK_FILTER=4, SETTLE_CYCLES=10, BLANK_FRAMES=2, PATTERN_FRAMES=3).
// Inputs are driven and outputs sampled on the falling clock edge. The pattern
// reference model counts unheld frames and advances modulo 4. Define
// LCD_BL_PWM_EN for both bench and RTL to exercise the backlight PWM.
module tb_lcd_bringup_sequencer;

    localparam int LF  = 4;
    localparam int SC  = 10;
    localparam int BF  = 2;
    localparam int PF  = 3;
    localparam int PWB = 8;

    logic           CLK_SYS = 1'b0;
    logic           rst = 1'b0;
    logic           pll_lock = 1'b0;
    logic           lcd_vsync = 1'b1;
    logic           pattern_hold = 1'b0;
    logic [PWB-1:0] bl_duty = '0;
    logic           vga_rst_n;
    logic           lcd_den_en;
    logic           bl_en;
    logic [1:0]     pattern_sel;
    logic           ready;
    logic [2:0]     state_o;

    int checks = 0;
    int errors = 0;
    int model_pat = 0;
    int model_cnt = 0;

    lcd_bringup_sequencer #(
        .LOCK_FILTER    (LF),
        .SETTLE_CYCLES  (SC),
        .BLANK_FRAMES   (BF),
        .PATTERN_FRAMES (PF),
        .PWM_BITS       (PWB)
    ) dut (
        .CLK_SYS      (CLK_SYS),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .lcd_vsync    (lcd_vsync),
        .pattern_hold (pattern_hold),
        .bl_duty      (bl_duty),
        .vga_rst_n    (vga_rst_n),
        .lcd_den_en   (lcd_den_en),
        .bl_en        (bl_en),
        .pattern_sel  (pattern_sel),
        .ready        (ready),
        .state_o      (state_o)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK_SYS);
    endtask

    // One VSYNC frame: random low width, random gap long enough to be processed.
    task automatic vsync_pulse();
        int low_len;
        int gap_len;
        low_len = $urandom_range(1, 4);
        gap_len = $urandom_range(6, 10);
        lcd_vsync = 1'b0;
        wait_cycles(low_len);
        lcd_vsync = 1'b1;
        wait_cycles(gap_len);
    endtask

    // Reference model: only unheld frames count; every PF of them bumps the pattern.
    task automatic model_frame();
        if (pattern_hold) begin
            model_cnt = 0;
        end else begin
            model_cnt++;
            if (model_cnt == PF) begin
                model_cnt = 0;
                model_pat = (model_pat + 1) % 4;
            end
        end
    endtask

    task automatic set_hold(input logic v);
        pattern_hold = v;
        if (v) model_cnt = 0;
    endtask

    task automatic measure_rise(output int rise);
        rise = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK_SYS);
            if (vga_rst_n === 1'b1) begin
                rise = i;
                break;
            end
        end
    endtask

    task automatic measure_settle(output int n);
        n = 0;
        while (state_o === 3'd2 && n < 200) begin
            @(negedge CLK_SYS);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pll_lock = 1'b0;
        lcd_vsync = 1'b1;
        set_hold(1'b0);
        bl_duty = PWB'($urandom_range(1, 255));
        wait_cycles(3);
        if (vga_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_vga: got %b expected 0", vga_rst_n); end
        checks++;
        if (lcd_den_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_den: got %b expected 0", lcd_den_en); end
        checks++;
        if (bl_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_bl: got %b expected 0", bl_en); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if (pattern_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_pattern: got %0d expected 0", pattern_sel); end
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        checks++;
    endtask

    // Lock stable from reset release: 2 sync cycles + LF filter cycles to SETTLE.
    task automatic test_bringup();
        int rise;
        int settle_len;
        pll_lock = 1'b1;
        wait_cycles(1);
        rst = 1'b1;
        measure_rise(rise);
        if (rise != 2 + LF) begin errors++; $display("[TB] FAIL bringup_rise: got %0d expected %0d", rise, 2 + LF); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL settle_ready: got %b expected 0", ready); end
        checks++;
        measure_settle(settle_len);
        if (settle_len != SC) begin errors++; $display("[TB] FAIL settle_len: got %0d expected %0d", settle_len, SC); end
        checks++;
        if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL blank_state: got %0d expected 3", state_o); end
        checks++;
        for (int f = 1; f < BF; f++) vsync_pulse();
        if (ready !== 1'b0 || state_o !== 3'd3) begin
            errors++; $display("[TB] FAIL blank_early: got ready=%b state=%0d expected ready=0 state=3", ready, state_o);
        end
        checks++;
        vsync_pulse();
        if (state_o !== 3'd4 || ready !== 1'b1 || lcd_den_en !== 1'b1 || vga_rst_n !== 1'b1) begin
            errors++; $display("[TB] FAIL run_entry: got state=%0d ready=%b den=%b vga=%b expected 4/1/1/1",
                               state_o, ready, lcd_den_en, vga_rst_n);
        end
        checks++;
`ifndef LCD_BL_PWM_EN
        if (bl_en !== 1'b1) begin errors++; $display("[TB] FAIL run_bl: got %b expected 1", bl_en); end
        checks++;
`endif
        if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL run_pattern: got %0d expected %0d", pattern_sel, model_pat); end
        checks++;
        model_cnt = 0;
    endtask

    // Twelve frames: advances at 3, 6, 9 and the wrap at 12; frame 3 also checks latency.
    task automatic test_patterns();
        int old_pat;
        for (int p = 1; p <= 12; p++) begin
            if (p == 3) begin
                old_pat = model_pat;
                lcd_vsync = 1'b0;
                wait_cycles(3);
                if (pattern_sel !== 2'(old_pat)) begin errors++; $display("[TB] FAIL pat_latency_pre: got %0d expected %0d", pattern_sel, old_pat); end
                checks++;
                wait_cycles(1);
                lcd_vsync = 1'b1;
                if (pattern_sel !== 2'((old_pat + 1) % 4)) begin
                    errors++; $display("[TB] FAIL pat_latency_post: got %0d expected %0d", pattern_sel, (old_pat + 1) % 4);
                end
                checks++;
                wait_cycles(8);
            end else begin
                vsync_pulse();
            end
            model_frame();
            if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL pattern_step%0d: got %0d expected %0d", p, pattern_sel, model_pat); end
            checks++;
        end
    endtask

    task automatic test_hold();
        int held;
        vsync_pulse();
        model_frame();
        held = model_pat;
        set_hold(1'b1);
        for (int p = 1; p <= 5; p++) begin
            vsync_pulse();
            model_frame();
            if (pattern_sel !== 2'(held)) begin errors++; $display("[TB] FAIL hold_frozen%0d: got %0d expected %0d", p, pattern_sel, held); end
            checks++;
        end
        set_hold(1'b0);
        for (int p = 1; p <= PF; p++) begin
            vsync_pulse();
            model_frame();
            if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL hold_release%0d: got %0d expected %0d", p, pattern_sel, model_pat); end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 24; p++) begin
            if ($urandom_range(0, 3) == 0) set_hold(1'($urandom_range(0, 1)));
            vsync_pulse();
            model_frame();
            if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL random_frame%0d: got %0d expected %0d", p, pattern_sel, model_pat); end
            checks++;
        end
        set_hold(1'b0);
    endtask

    // Lock loss in RUN, then relock through the full sequence with the pattern retained.
    task automatic test_lock_loss();
        int kept;
        int rise;
        int settle_len;
        kept = model_pat;
        pll_lock = 1'b0;
        wait_cycles(2);
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL loss_too_early: got %b expected 1", ready); end
        checks++;
        wait_cycles(1);
        if (ready !== 1'b0 || lcd_den_en !== 1'b0 || bl_en !== 1'b0 || vga_rst_n !== 1'b0) begin
            errors++; $display("[TB] FAIL loss_outputs: got ready=%b den=%b bl=%b vga=%b expected all 0",
                               ready, lcd_den_en, bl_en, vga_rst_n);
        end
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL loss_state: got %0d expected 1", state_o); end
        checks++;
        if (pattern_sel !== 2'(kept)) begin errors++; $display("[TB] FAIL loss_pattern: got %0d expected %0d", pattern_sel, kept); end
        checks++;
        pll_lock = 1'b1;
        measure_rise(rise);
        if (rise != 2 + LF) begin errors++; $display("[TB] FAIL relock_rise: got %0d expected %0d", rise, 2 + LF); end
        checks++;
        measure_settle(settle_len);
        if (settle_len != SC) begin errors++; $display("[TB] FAIL relock_settle: got %0d expected %0d", settle_len, SC); end
        checks++;
        for (int f = 0; f < BF; f++) vsync_pulse();
        if (ready !== 1'b1 || pattern_sel !== 2'(kept)) begin
            errors++; $display("[TB] FAIL relock_run: got ready=%b pat=%0d expected ready=1 pat=%0d", ready, pattern_sel, kept);
        end
        checks++;
        model_cnt = 0;
        for (int p = 1; p <= PF; p++) begin
            vsync_pulse();
            model_frame();
        end
        if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL relock_advance: got %0d expected %0d", pattern_sel, model_pat); end
        checks++;
    endtask

    // One-cycle lock dropout during the filter: the synced low is seen 3 edges
    // later and LF fresh lock cycles are needed from there.
    task automatic test_glitch();
        int k;
        int rise;
        int settle_len;
        rst = 1'b0;
        pll_lock = 1'b1;
        model_pat = 0;
        model_cnt = 0;
        wait_cycles(2);
        k = $urandom_range(1, 3);
        rst = 1'b1;
        rise = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK_SYS);
            if (vga_rst_n === 1'b1) begin
                rise = i;
                break;
            end
            if (i == k) pll_lock = 1'b0;
            if (i == k + 1) pll_lock = 1'b1;
        end
        if (rise != k + 3 + LF) begin errors++; $display("[TB] FAIL glitch_rise: got %0d expected %0d (k=%0d)", rise, k + 3 + LF, k); end
        checks++;
        measure_settle(settle_len);
        for (int f = 0; f < BF; f++) vsync_pulse();
        if (state_o !== 3'd4 || pattern_sel !== 2'd0) begin
            errors++; $display("[TB] FAIL glitch_run: got state=%0d pat=%0d expected 4/0", state_o, pattern_sel);
        end
        checks++;
    endtask

`ifdef LCD_BL_PWM_EN
    task automatic test_pwm();
        int highs;
        bl_duty = 8'd64;
        wait_cycles(4);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK_SYS);
            if (bl_en === 1'b1) highs++;
        end
        if (highs != 64) begin errors++; $display("[TB] FAIL pwm_duty64: got %0d expected 64", highs); end
        checks++;
        bl_duty = 8'd0;
        wait_cycles(4);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK_SYS);
            if (bl_en === 1'b1) highs++;
        end
        if (highs != 0) begin errors++; $display("[TB] FAIL pwm_duty0: got %0d expected 0", highs); end
        checks++;
    endtask
`endif

    // Reset asserted between clock edges must clear everything before the next edge.
    task automatic test_async_reset();
        for (int p = 1; p <= PF; p++) begin
            vsync_pulse();
            model_frame();
        end
        if (pattern_sel !== 2'(model_pat)) begin errors++; $display("[TB] FAIL pre_reset_pattern: got %0d expected %0d", pattern_sel, model_pat); end
        checks++;
        @(negedge CLK_SYS);
        #2;
        rst = 1'b0;
        #1;
        if (vga_rst_n !== 1'b0 || lcd_den_en !== 1'b0 || bl_en !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset_outputs: got vga=%b den=%b bl=%b ready=%b expected all 0",
                               vga_rst_n, lcd_den_en, bl_en, ready);
        end
        checks++;
        if (state_o !== 3'd0 || pattern_sel !== 2'd0) begin
            errors++; $display("[TB] FAIL async_reset_state: got state=%0d pat=%0d expected 0/0", state_o, pattern_sel);
        end
        checks++;
        wait_cycles(2);
    endtask

    initial begin
        $display("[TB] starting lcd_bringup_sequencer bench");
        test_reset();
        test_bringup();
        test_patterns();
        test_hold();
        test_random();
        test_lock_loss();
        test_glitch();
`ifdef LCD_BL_PWM_EN
        test_pwm();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
